// File: rtl/code_block_desegment.sv
// code_block_desegment
//   Receive-side block desegmenter. Consumes the framed serial stream
//   (start, filler, data, optional CRC24B, stop), drops filler and CRC bits,
//   forwards payload bits and reports one status record per block.
//
// Ports
//   clk, reset       : clock, asynchronous active-high reset
//   in_bit/in_valid  : serial bit and its qualifier (one bit per cycle)
//   start/stop       : block framing pulses (in_valid=0 during them)
//   filling/crc      : qualify the current bit as filler / appended CRC
//   block_size       : sampled on start, 1 = 6144-bit block, 0 = 1056-bit block
//   dout/dout_wr     : registered payload bit and FIFO write strobe
//   blk_*            : registered per-block status, valid with blk_done
module code_block_desegment (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_bit,
  input  logic        in_valid,
  input  logic        start,
  input  logic        filling,
  input  logic        crc,
  input  logic        stop,
  input  logic        block_size,
  output logic        dout,
  output logic        dout_wr,
  output logic        blk_done,
  output logic        blk_crc_present,
  output logic        blk_crc_ok,
  output logic        blk_len_err,
  output logic        blk_proto_err,
  output logic [7:0]  blk_index,
  output logic [12:0] blk_data_bits
);

  localparam logic [23:0] CRC_POLY = 24'h800063;
  localparam logic [13:0] K_BIG    = 14'd6144;
  localparam logic [13:0] K_SMALL  = 14'd1056;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DATA, S_CRCB} state_t;

  state_t      r_state, w_next;
  logic        w_close, w_perr, w_idle_err, w_fill, w_data, w_crcb;
  logic [4:0]  w_crc_sel;

  logic        r_dout, r_dout_wr, r_done;
  logic        r_pres, r_ok, r_len, r_proto;
  logic [7:0]  r_index, r_blk_seq;
  logic [12:0] r_nbits;
  logic        r_k_big, r_crc_bad, r_perr, r_idle_err;
  logic [13:0] r_total;
  logic [12:0] r_data_cnt;
  logic [5:0]  r_crc_cnt;
  logic [23:0] r_crc;

  // CRC24B, MSB first
  function automatic logic [23:0] crc_step(input logic [23:0] c, input logic b);
    logic fb;
    fb = c[23] ^ b;
    return {c[22:0], 1'b0} ^ (fb ? CRC_POLY : 24'h0);
  endfunction

  function automatic logic [13:0] sat_inc14(input logic [13:0] v);
    return (v == 14'h3fff) ? v : v + 14'd1;
  endfunction

  function automatic logic [12:0] sat_inc13(input logic [12:0] v);
    return (v == 13'h1fff) ? v : v + 13'd1;
  endfunction

  function automatic logic [5:0] sat_inc6(input logic [5:0] v);
    return (v == 6'h3f) ? v : v + 6'd1;
  endfunction

  // The CRC register stops updating once CRC bits arrive, so it is the
  // frozen value; bit n of the appended CRC compares with bit (23-n).
  assign w_crc_sel = 5'd23 - r_crc_cnt[4:0];

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // next-state logic; start always opens a fresh block, even mid-block
  always_comb begin
    w_next = r_state;
    if (start)
      w_next = S_FILL;
    else if (r_state != S_IDLE) begin
      if (stop)        w_next = S_IDLE;
      else if (w_crcb) w_next = S_CRCB;
      else if (w_data) w_next = S_DATA;
    end
  end

  // bit classification and framing events
  always_comb begin
    w_close    = 1'b0;
    w_perr     = 1'b0;
    w_idle_err = 1'b0;
    w_fill     = 1'b0;
    w_data     = 1'b0;
    w_crcb     = 1'b0;
    if (r_state == S_IDLE) begin
      w_idle_err = ~start & (in_valid | stop);
    end else begin
      w_close = start | stop;
      if (in_valid && !start && !stop) begin
        if (filling && crc)          w_perr = 1'b1;
        else if (filling) begin
          if (r_state == S_FILL)     w_fill = 1'b1;
          else                       w_perr = 1'b1;
        end
        else if (crc)                w_crcb = 1'b1;
        else if (r_state == S_CRCB)  w_perr = 1'b1;
        else                         w_data = 1'b1;
      end
    end
  end

  // per-block counters, CRC, output and status registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dout     <= 1'b0;
      r_dout_wr  <= 1'b0;
      r_done     <= 1'b0;
      r_pres     <= 1'b0;
      r_ok       <= 1'b0;
      r_len      <= 1'b0;
      r_proto    <= 1'b0;
      r_index    <= 8'd0;
      r_blk_seq  <= 8'd0;
      r_nbits    <= 13'd0;
      r_k_big    <= 1'b0;
      r_crc_bad  <= 1'b0;
      r_perr     <= 1'b0;
      r_idle_err <= 1'b0;
      r_total    <= 14'd0;
      r_data_cnt <= 13'd0;
      r_crc_cnt  <= 6'd0;
      r_crc      <= 24'd0;
    end else begin
      r_dout_wr <= w_data;
      if (w_data) r_dout <= in_bit;

      r_done <= w_close;
      if (w_close) begin
        r_pres    <= (r_crc_cnt != 6'd0);
        r_ok      <= ~r_crc_bad & ((r_crc_cnt == 6'd0) | (r_crc_cnt == 6'd24));
        r_len     <= (r_total != (r_k_big ? K_BIG : K_SMALL));
        // a start that closes a block is itself a framing violation
        r_proto   <= r_perr | start;
        r_nbits   <= r_data_cnt;
        r_index   <= r_blk_seq;
        r_blk_seq <= r_blk_seq + 8'd1;
      end

      if (start) begin
        r_k_big    <= block_size;
        r_total    <= 14'd0;
        r_data_cnt <= 13'd0;
        r_crc_cnt  <= 6'd0;
        r_crc      <= 24'd0;
        r_crc_bad  <= 1'b0;
        // errors seen while idle have no block of their own; charge the next one
        r_perr     <= r_idle_err;
        r_idle_err <= 1'b0;
      end else begin
        if (w_idle_err) r_idle_err <= 1'b1;
        if (w_perr)     r_perr <= 1'b1;
        if (w_fill || w_data || w_crcb) r_total <= sat_inc14(r_total);
        if (w_data) begin
          r_crc      <= crc_step(r_crc, in_bit);
          r_data_cnt <= sat_inc13(r_data_cnt);
        end
        if (w_crcb) begin
          if ((r_crc_cnt < 6'd24) && (in_bit != r_crc[w_crc_sel])) r_crc_bad <= 1'b1;
          r_crc_cnt <= sat_inc6(r_crc_cnt);
        end
      end
    end
  end

  assign dout            = r_dout;
  assign dout_wr         = r_dout_wr;
  assign blk_done        = r_done;
  assign blk_crc_present = r_pres;
  assign blk_crc_ok      = r_ok;
  assign blk_len_err     = r_len;
  assign blk_proto_err   = r_proto;
  assign blk_index       = r_index;
  assign blk_data_bits   = r_nbits;

endmodule

// File: tb/tb_code_block_desegment.sv
module tb_code_block_desegment;

  logic        clk = 1'b0;
  logic        reset, in_bit, in_valid, start, filling, crc, stop, block_size;
  logic        dout, dout_wr, blk_done, blk_crc_present, blk_crc_ok;
  logic        blk_len_err, blk_proto_err;
  logic [7:0]  blk_index;
  logic [12:0] blk_data_bits;

  code_block_desegment dut (
    .clk(clk), .reset(reset), .in_bit(in_bit), .in_valid(in_valid),
    .start(start), .filling(filling), .crc(crc), .stop(stop),
    .block_size(block_size), .dout(dout), .dout_wr(dout_wr),
    .blk_done(blk_done), .blk_crc_present(blk_crc_present),
    .blk_crc_ok(blk_crc_ok), .blk_len_err(blk_len_err),
    .blk_proto_err(blk_proto_err), .blk_index(blk_index),
    .blk_data_bits(blk_data_bits)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        pres, ok, len, proto;
    logic [7:0]  idx;
    logic [12:0] nbits;
    int          qleft;
  } rec_t;

  int          n_chk = 0;
  int          n_err = 0;
  int          n_wr, n_bad, exp_idx;
  rec_t        dq[$];
  logic        expq[$];
  logic        pay[6144];
  logic [23:0] crc_acc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] crc24b(input logic [23:0] c, input logic b);
    logic fb;
    fb = c[23] ^ b;
    c  = {c[22:0], 1'b0};
    if (fb) c = c ^ 24'h800063;
    return c;
  endfunction

  // output monitor, sampled on the falling edge
  always @(negedge clk) begin
    rec_t r;
    if (dout_wr) begin
      n_wr++;
      if (expq.size() == 0) n_bad++;
      else if (dout !== expq.pop_front()) n_bad++;
    end
    if (blk_done) begin
      r.pres  = blk_crc_present;
      r.ok    = blk_crc_ok;
      r.len   = blk_len_err;
      r.proto = blk_proto_err;
      r.idx   = blk_index;
      r.nbits = blk_data_bits;
      r.qleft = expq.size();
      dq.push_back(r);
    end
  end

  task automatic cyc(input logic v, input logic b, input logic f, input logic c,
                     input logic st, input logic sp, input logic bs);
    in_valid = v; in_bit = b; filling = f; crc = c;
    start = st; stop = sp; block_size = bs;
    @(posedge clk); #1;
  endtask

  task automatic send_data(input logic b);
    expq.push_back(b);
    crc_acc = crc24b(crc_acc, b);
    cyc(1, b, 0, 0, 0, 0, 0);
  endtask

  task automatic run_block(input logic bs, input int nfill, input int ndata,
                           input int ncrc, input int flip, input int badfill_at,
                           input bit dostop);
    logic b;
    crc_acc = 24'd0;
    cyc(0, 0, 0, 0, 1, 0, bs);
    for (int i = 0; i < nfill; i++) cyc(1, i[0], 1, 0, 0, 0, 0);
    for (int i = 0; i < ndata; i++) begin
      if (i == badfill_at) cyc(1, 1, 1, 0, 0, 0, 0);
      send_data(pay[i]);
    end
    for (int n = 0; n < ncrc; n++) begin
      b = crc_acc[23-n] ^ (n == flip);
      cyc(1, b, 0, 1, 0, 0, 0);
    end
    if (dostop) cyc(0, 0, 0, 0, 0, 1, 0);
  endtask

  task automatic wait_done(input int need);
    for (int i = 0; i < 10 && dq.size() < need; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    chk("done_seen", dq.size(), need);
  endtask

  task automatic check_rec(input string tag, input logic pres, input logic ok,
                           input logic len, input logic proto, input int nbits);
    rec_t r;
    if (dq.size() == 0) return;
    r = dq.pop_front();
    chk({tag, ".crc_present"}, r.pres, pres);
    chk({tag, ".crc_ok"}, r.ok, ok);
    chk({tag, ".len_err"}, r.len, len);
    chk({tag, ".proto_err"}, r.proto, proto);
    chk({tag, ".data_bits"}, r.nbits, nbits);
    chk({tag, ".index"}, r.idx, exp_idx);
    chk({tag, ".wr_after_done"}, r.qleft, 0);
    exp_idx++;
  endtask

  task automatic check_writes(input string tag, input int nexp);
    chk({tag, ".n_wr"}, n_wr, nexp);
    chk({tag, ".dout_bad"}, n_bad, 0);
    n_wr = 0;
    n_bad = 0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, ".dout_wr"}, dout_wr, 0);
    chk({tag, ".dout"}, dout, 0);
    chk({tag, ".blk_done"}, blk_done, 0);
    chk({tag, ".flags"}, {blk_crc_present, blk_crc_ok, blk_len_err, blk_proto_err}, 0);
    chk({tag, ".index"}, blk_index, 0);
    chk({tag, ".data_bits"}, blk_data_bits, 0);
  endtask

  initial begin
    n_wr = 0; n_bad = 0; exp_idx = 0;
    reset = 1'b1;
    in_valid = 0; in_bit = 0; filling = 0; crc = 0;
    start = 0; stop = 0; block_size = 0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    reset = 1'b0;
    cyc(0, 0, 0, 0, 0, 0, 0);

    // all-zero payload with zero CRC
    for (int i = 0; i < 6144; i++) pay[i] = 1'b0;
    run_block(0, 40, 992, 24, -1, -1, 1);
    wait_done(1);
    check_rec("zero", 1, 1, 0, 0, 992);
    check_writes("zero", 992);

    // random payload, CRC bit 5 corrupted, then intact
    for (int i = 0; i < 6144; i++) pay[i] = logic'($urandom_range(0, 1));
    run_block(0, 40, 992, 24, 5, -1, 1);
    wait_done(1);
    check_rec("crc_bad", 1, 0, 0, 0, 992);
    check_writes("crc_bad", 992);
    run_block(0, 40, 992, 24, -1, -1, 1);
    wait_done(1);
    check_rec("crc_good", 1, 1, 0, 0, 992);
    check_writes("crc_good", 992);

    // large block without CRC
    run_block(1, 0, 6144, 0, -1, -1, 1);
    wait_done(1);
    check_rec("big", 0, 1, 0, 0, 6144);
    check_writes("big", 6144);

    // one bit short of K
    run_block(0, 0, 1031, 24, -1, -1, 1);
    wait_done(1);
    check_rec("short", 1, 1, 1, 0, 1031);
    check_writes("short", 1031);

    // filler bit after 10 data bits is dropped and flagged
    run_block(0, 0, 1032, 24, -1, 10, 1);
    wait_done(1);
    check_rec("fill_in_data", 1, 1, 0, 1, 1032);
    check_writes("fill_in_data", 1032);

    // start after 500 data bits aborts, next block is clean
    run_block(0, 40, 500, 0, -1, -1, 0);
    run_block(0, 40, 992, 24, -1, -1, 1);
    wait_done(2);
    check_rec("abort", 0, 1, 1, 1, 500);
    check_rec("after_abort", 1, 1, 0, 0, 992);
    check_writes("abort_pair", 1492);

    // reset in the middle of DATA discards the block
    cyc(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 300; i++) send_data(pay[i]);
    in_valid = 0; reset = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check_idle_outputs("mid_reset");
    expq.delete();
    n_wr = 0; n_bad = 0;
    reset = 1'b0;
    exp_idx = 0;
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0);
    chk("mid_reset.no_done", dq.size(), 0);
    chk("mid_reset.no_wr", n_wr, 0);
    run_block(0, 40, 992, 24, -1, -1, 1);
    wait_done(1);
    check_rec("post_reset", 1, 1, 0, 0, 992);
    check_writes("post_reset", 992);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
